// File: rtl/sync_sub_pkg.sv
// Constants and the seven-segment decoder shared by the sync_sub digit
// counter and its button front end.
package sync_sub_pkg;

    localparam logic [3:0]  DIGIT_MAX = 4'hF;
    localparam int unsigned BTN_CNT_W = 16;

    // BCD7 decoder, active-high segments ordered {g,f,e,d,c,b,a}, hex 0-F.
    function automatic logic [6:0] bcd7(input logic [3:0] val);
        logic [6:0] seg;
        seg = 7'h00;
        case (val)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sync_sub_btn_pulse.sv
// Button front end: two-flop synchronizer, consecutive-clock debounce and
// rising-edge detector producing a registered one-cycle dec_pulse.
module sub_btn_pulse
    import sync_sub_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic BTNS,
    output logic dec_pulse
);

    localparam logic [BTN_CNT_W-1:0] CNT_TC = BTN_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync_meta_q;
    logic                 btn_sync_q;
    logic                 btn_stable_q, btn_stable_d;
    logic                 stable_prev_q;
    logic [BTN_CNT_W-1:0] cnt_q, cnt_d;
    logic                 dec_pulse_q;

    // Counter runs only while the synchronized input disagrees; any agreement restarts it.
    always_comb begin
        cnt_d        = '0;
        btn_stable_d = btn_stable_q;
        if (btn_sync_q != btn_stable_q) begin
            if (cnt_q == CNT_TC) begin
                btn_stable_d = btn_sync_q;
            end else begin
                cnt_d = cnt_q + BTN_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta_q   <= 1'b0;
            btn_sync_q    <= 1'b0;
            btn_stable_q  <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
            dec_pulse_q   <= 1'b0;
        end else begin
            sync_meta_q   <= BTNS;
            btn_sync_q    <= sync_meta_q;
            btn_stable_q  <= btn_stable_d;
            stable_prev_q <= btn_stable_q;
            cnt_q         <= cnt_d;
            dec_pulse_q   <= btn_stable_q & ~stable_prev_q;
        end
    end

    assign dec_pulse = dec_pulse_q;

endmodule

// File: rtl/sync_sub.sv
// Debounced-button hex down-counter with load, wrap/saturate at zero,
// borrow pulse and active-low seven-segment output.
module sync_sub
    import sync_sub_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [3:0]  INIT            = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BTNS,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       wrap,
    output logic [3:0] digit,
    output logic       zero,
    output logic       borrow,
    output logic [6:0] leds
);

    logic       dec_pulse;
    logic [3:0] digit_q, digit_d;
    logic       borrow_q, borrow_d;

    sub_btn_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_pulse (
        .clk      (clk),
        .reset    (reset),
        .BTNS     (BTNS),
        .dec_pulse(dec_pulse)
    );

    // Load outranks a coincident press, which is simply dropped.
    always_comb begin
        digit_d  = digit_q;
        borrow_d = 1'b0;
        if (load) begin
            digit_d = load_val;
        end else if (dec_pulse) begin
            if (digit_q != 4'h0) begin
                digit_d = digit_q - 4'h1;
            end else if (wrap) begin
                digit_d  = DIGIT_MAX;
                borrow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_q  <= INIT;
            borrow_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            borrow_q <= borrow_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = borrow_q;
    assign zero   = (digit_q == 4'h0);
    assign leds   = ~bcd7(digit_q);

endmodule
